// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drives a one-cycle-latency FIFO read port and re-presents the data
// as a valid/ready stream through a 2-entry prefetch buffer.
module fifo_rd_stream #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_rden,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [1:0]        occ
);
  logic [DWIDTH-1:0] mem_q [2];
  logic [1:0] occ_q, occ_d;
  logic head_q, head_d, tail_q, tail_d, inflight_q, inflight_d;
  logic pop, clr;
  logic [2:0] credit;
  assign m_valid = occ_q != 2'd0;
  assign m_data = mem_q[head_q];
  assign occ = occ_q;
  always_comb begin
    clr = rst || flush;
    pop = m_valid && m_ready;
    // words held plus the one in flight, after this cycle's pop; a new read may only claim a free slot
    credit = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    fifo_rden = !clr && !fifo_empty && credit < 3'd2;
    occ_d = clr ? 2'd0 : occ_q + {1'b0, inflight_q} - {1'b0, pop};
    head_d = !clr && (head_q ^ pop);
    tail_d = !clr && (tail_q ^ inflight_q);
    inflight_d = fifo_rden;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= 2'd0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      inflight_q <= inflight_d;
    end
  end
  always_ff @(posedge clk) begin
    if (inflight_q && !clr) mem_q[tail_q] <= fifo_dout;
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO model plus scoreboard of buffered words, checked every cycle,
// with per-scenario tasks adding their own timing and ordering checks.
module tb_fifo_rd_stream;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_rden;
  logic [W-1:0] fifo_dout = '0;
  logic fifo_empty = 1'b1;
  logic flush = 1'b0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic [1:0] occ;
  logic hold = 1'b1;
  logic [W-1:0] mq[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] got[$];
  logic [W-1:0] pend = '0;
  bit infl = 1'b0;
  int errors = 0;
  int checks = 0;

  fifo_rd_stream #(.DWIDTH(W)) dut (
    .clk(clk), .rst(rst), .fifo_rden(fifo_rden), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .occ(occ)
  );

  always #5 clk = ~clk;

  // FIFO model and scoreboard: update read-side inputs on the falling edge, then sample
  always @(negedge clk) begin
    bit mv_e, rd_e;
    fifo_empty = (mq.size() == 0) || hold;
    fifo_dout = infl ? pend : W'($urandom);
    #1;
    mv_e = sb.size() != 0;
    rd_e = !rst && !flush && !fifo_empty && (sb.size() + int'(infl) - int'(mv_e && m_ready)) < 2;
    checks++;
    if (m_valid !== mv_e) begin errors++; $display("FAIL m_valid: got %b exp %b at %0t", m_valid, mv_e, $time); end
    checks++;
    if (occ !== 2'(sb.size())) begin errors++; $display("FAIL occ: got %0d exp %0d at %0t", occ, sb.size(), $time); end
    checks++;
    if (fifo_rden !== rd_e) begin errors++; $display("FAIL fifo_rden: got %b exp %b at %0t", fifo_rden, rd_e, $time); end
    checks++;
    if (fifo_rden && fifo_empty) begin errors++; $display("FAIL rden_while_empty: got 1 exp 0 at %0t", $time); end
    if (mv_e) begin
      checks++;
      if (m_data !== sb[0]) begin errors++; $display("FAIL m_data: got %h exp %h at %0t", m_data, sb[0], $time); end
    end
    if (mv_e && m_ready) got.push_back(sb.pop_front());
    if (rst || flush) begin
      sb.delete();
      infl = 1'b0;
    end else begin
      if (infl) sb.push_back(pend);
      infl = rd_e;
    end
    if (rd_e) pend = mq.pop_front();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      hold = 1'b1; m_ready = 1'b1; flush = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) mq.push_back(W'(16'h11 + i));
    for (int c = 0; c < 3; c++) begin
      tick();
      rst = 1'b1; hold = 1'b0; m_ready = 1'b1;
      @(negedge clk); #2;
      checks++;
      if (fifo_rden !== 1'b0 || m_valid !== 1'b0 || occ !== 2'd0) begin
        errors++; $display("FAIL reset: rden=%b m_valid=%b occ=%0d exp 0/0/0", fifo_rden, m_valid, occ);
      end
    end
    tick();
    rst = 1'b0; hold = 1'b1;
    mq.delete();
  endtask

  task automatic test_single();
    got.delete();
    mq.push_back(W'(16'hA5));
    for (int c = 0; c < 11; c++) begin
      tick();
      hold = c < 5; m_ready = 1'b1;
      @(negedge clk); #2;
      checks++;
      if (fifo_rden !== (c == 5)) begin errors++; $display("FAIL single_rden: c=%0d got %b exp %b", c, fifo_rden, c == 5); end
      checks++;
      if (m_valid !== (c == 7)) begin errors++; $display("FAIL single_valid: c=%0d got %b exp %b", c, m_valid, c == 7); end
      checks++;
      if (occ !== ((c == 7) ? 2'd1 : 2'd0)) begin errors++; $display("FAIL single_occ: c=%0d got %0d", c, occ); end
      if (c == 7) begin
        checks++;
        if (m_data !== W'(16'hA5)) begin errors++; $display("FAIL single_data: got %h exp 00a5", m_data); end
      end
    end
  endtask

  task automatic test_stream();
    int first, last, nv;
    got.delete();
    for (int i = 0; i < 16; i++) mq.push_back(W'(i));
    first = -1; last = -1; nv = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      hold = 1'b0; m_ready = 1'b1;
      @(negedge clk); #2;
      if (m_valid) begin
        nv++;
        if (first < 0) first = c;
        last = c;
      end
    end
    checks++;
    if (nv != 16 || last - first != 15) begin errors++; $display("FAIL stream_gapless: got %0d valid over span %0d exp 16/15", nv, last - first); end
    checks++;
    if (first != 2) begin errors++; $display("FAIL stream_latency: got first valid %0d exp 2", first); end
    checks++;
    if (got.size() != 16) begin errors++; $display("FAIL stream_count: got %0d exp 16", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(i)) begin errors++; $display("FAIL stream_order: idx %0d got %h exp %h", i, got[i], W'(i)); end
    end
  endtask

  task automatic test_backpressure();
    logic pv, pr, pread;
    logic [W-1:0] pd;
    got.delete();
    for (int i = 0; i < 10; i++) mq.push_back(W'(16'h30 + i));
    pv = 1'b0; pr = 1'b0; pread = 1'b0; pd = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      hold = 1'b0; m_ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk); #2;
      if (pv && !pr) begin
        checks++;
        if (m_data !== pd || m_valid !== 1'b1) begin errors++; $display("FAIL bp_stable: got %h/%b exp %h/1", m_data, m_valid, pd); end
      end
      checks++;
      if (int'(occ) + int'(pread) > 2) begin errors++; $display("FAIL bp_outstanding: got %0d exp <=2", int'(occ) + int'(pread)); end
      pv = m_valid; pr = m_ready; pd = m_data; pread = fifo_rden;
    end
    checks++;
    if (got.size() != 10) begin errors++; $display("FAIL bp_count: got %0d exp 10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(16'h30 + i)) begin errors++; $display("FAIL bp_order: idx %0d got %h exp %h", i, got[i], W'(16'h30 + i)); end
    end
  endtask

  task automatic test_flush();
    got.delete();
    for (int i = 0; i < 4; i++) mq.push_back(W'(16'h50 + i));
    for (int c = 0; c < 14; c++) begin
      tick();
      hold = 1'b0; m_ready = (c == 3) || (c >= 6); flush = c == 4;
      @(negedge clk); #2;
      if (c == 3) begin
        checks++;
        if (occ !== 2'd2 || fifo_rden !== 1'b1) begin errors++; $display("FAIL flush_setup: occ=%0d rden=%b exp 2/1", occ, fifo_rden); end
      end
      if (c == 4) begin
        checks++;
        if (fifo_rden !== 1'b0) begin errors++; $display("FAIL flush_rden: got %b exp 0", fifo_rden); end
      end
      if (c == 5) begin
        checks++;
        if (occ !== 2'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: occ=%0d m_valid=%b exp 0/0", occ, m_valid); end
      end
    end
    flush = 1'b0;
    checks++;
    if (got.size() != 2 || got[0] !== W'(16'h50) || got[1] !== W'(16'h53)) begin
      errors++; $display("FAIL flush_seq: got %0d words %p exp 0050 0053", got.size(), got);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] n;
    bit ordered;
    got.delete();
    n = W'(16'h1000);
    for (int c = 0; c < 10000; c++) begin
      tick();
      while (mq.size() < 4) begin mq.push_back(n); n = n + 1'b1; end
      hold = $urandom_range(0, 3) == 0;
      m_ready = 1'($urandom_range(0, 1));
      flush = $urandom_range(0, 31) == 0;
      rst = $urandom_range(0, 499) == 0;
    end
    idle(6);
    mq.delete();
    ordered = 1'b1;
    for (int i = 1; i < got.size(); i++) if (got[i] <= got[i-1]) ordered = 1'b0;
    checks++;
    if (!ordered) begin errors++; $display("FAIL rand_order: delivered sequence not increasing"); end
    checks++;
    if (got.size() < 1000) begin errors++; $display("FAIL rand_progress: got %0d words exp >=1000", got.size()); end
  endtask

  initial begin
    test_reset();
    idle(3);
    test_single();
    idle(4);
    test_stream();
    idle(4);
    test_backpressure();
    idle(4);
    test_flush();
    idle(4);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-end adapter for the team's FIFOs, clocked in the FIFO's read domain. It drives the raw FIFO read port (`rden` / `dout` / `empty`, one-cycle read latency) and presents the data as a valid/ready stream. A 2-entry prefetch buffer sustains one word per cycle while the consumer applies arbitrary backpressure. A synchronous flush discards all buffered and in-flight words.

## Interface
- `DWIDTH`, default 8: data width; must match the FIFO `DWIDTH`.
- `clk` input 1: FIFO read-side clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `fifo_rden` output 1: read request to the FIFO port.
- `fifo_dout` input DWIDTH: FIFO read data, valid in the cycle after an accepted read.
- `fifo_empty` input 1: FIFO registered empty flag.
- `flush` input 1: synchronous discard of all buffered and in-flight data.
- `m_valid` output 1: stream word available.
- `m_ready` input 1: consumer accepts the word.
- `m_data` output DWIDTH: stream word, taken from the buffer head.
- `occ` output 2: number of words held in the buffer (0..2).

## Operation
- **State:**
  - 2-entry buffer with head/tail pointer bits.
  - `occ` register, 0..2.
  - `inflight` bit: a read was accepted last cycle, so data arrives this cycle.
- **Read request:**
  - `fifo_rden = !rst && !flush && !fifo_empty && (occ + inflight - pop) < 2`, where `pop = m_valid && m_ready`.
  - Evaluate the sum at 3-bit width.
  - `fifo_rden` is never high while `fifo_empty = 1`.
- **Accept and capture:**
  - A read issued in cycle k is accepted at edge k+1; `inflight` is 1 in cycle k+1.
  - At edge k+2, when `inflight = 1`, `fifo_dout` is written at the tail and the tail advances.
- **Stream output:**
  - `m_valid = (occ != 0)`; `m_data` = buffer[head].
  - On `pop`, the head advances.
  - `m_data` and `m_valid` stay stable while `m_valid && !m_ready`.
- **Simultaneous capture and pop:** `occ` is unchanged; both pointers advance. The pointer bits wrap 1 -> 0.
- **Overflow:** the credit rule keeps `occ + inflight <= 2` at all times, so the buffer never overflows. No overflow path exists in the RTL.
- **Flush:**
  - At the edge where `flush = 1`: `occ`, `head`, `tail` and `inflight` all clear to 0.
  - The data returning in the next cycle is not captured, because `inflight` is 0.
  - `fifo_rden` is 0 during the flush cycle.
  - Any pop in the flush cycle completes as a normal handshake from the consumer's view, and its word is dropped.
- **Reset:**
  - Same effect as flush.
  - Output values in and after reset: `fifo_rden = 0`, `m_valid = 0`, `occ = 0`, `m_data` = buffer[0] (contents don't-care).
  - Reset mid-transfer drops the in-flight word.

## Timing
- **Latency:** `fifo_rden` high in cycle k -> `m_valid` high in cycle k+2 (buffer was empty, no flush).
- **Empty to valid:** `fifo_empty` falling in cycle k gives `m_valid` in cycle k+2.
- **Throughput:** with `m_ready = 1` and the FIFO non-empty, `fifo_rden` stays high every cycle and `m_valid` stays high every cycle after the first two. That is 1 word/cycle.
- **Backpressure:** with `m_ready = 0` and a steady FIFO supply, at most 2 reads issue before `fifo_rden` drops. `fifo_rden` reasserts in the same cycle that `m_ready` rises, because of the `pop` term.
- **Combinational paths:** `fifo_rden` depends combinationally on `m_ready`, `flush`, `fifo_empty` and `rst`. No combinational path exists from `fifo_dout` to any output.

## Test plan
- **Reset:** hold `rst = 1` for 3 cycles with `fifo_empty = 0` -> `fifo_rden = 0`, `m_valid = 0`, `occ = 0` throughout.
- **Single word:** FIFO model holds 0xA5; `fifo_empty` falls at cycle 5, `m_ready = 1` -> `fifo_rden` high in cycle 5 only, `m_valid` high in cycle 7 only with `m_data = 0xA5`, `occ` returns to 0 in cycle 8.
- **Streaming:** 16 words 0x00..0x0F, `m_ready = 1` -> 16 consecutive `m_valid` cycles, in order, no gaps, no `fifo_rden` while empty.
- **Backpressure:** 10 words, `m_ready` toggling 1,0,0,1 repeating -> exactly 2 reads outstanding at most, `occ <= 2`, `m_data` stable while stalled, all 10 words delivered in order with no loss or duplication.
- **Flush:** flush asserted in the cycle after `fifo_rden` with `occ = 2` -> next cycle `occ = 0` and `m_valid = 0`; the returning word is not delivered; subsequent words resume with correct ordering.
- **Random:** randomized `fifo_empty`, `m_ready` and `flush` for 10k cycles against a scoreboard -> no `fifo_rden` while empty, no overflow, and the delivered sequence equals the read sequence minus flushed words.
